axis_m_rr_sched: RTL and testbench

//  Round-robin scheduler that shares one AXI-Stream master port among NUM_REQ

---
 rtl/axis_m_rr_sched_if.sv | 12 +
 rtl/axis_m_rr_sched.sv | 130 +++++++++++++
 tb/tb_axis_m_rr_sched.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/axis_m_rr_sched_if.sv
// AXI-Stream bus bundle for the round-robin scheduler's master port.
interface axis_m_rr_sched_if #(
  parameter int unsigned DATA_W = 32
);
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_m_rr_sched.sv
// Round-robin scheduler: shares one AXI-Stream master among NUM_REQ requesters,
// sending a fixed PKT_LEN-beat packet per grant.
module axis_m_rr_sched #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned PKT_LEN = 4
) (
  input  logic                      aclk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] data_in,
  output logic [NUM_REQ-1:0]        pop,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        grant,
  output logic                      busy,
  axis_m_rr_sched_if.master         m_axis
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);
  localparam int unsigned CntW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(PKT_LEN - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_REQ - 1);

  typedef enum logic {StIdle, StSend} state_e;

  state_e              state_q, state_d;
  logic [NUM_REQ-1:0]  grant_q, grant_d;
  logic [IdxW-1:0]     last_q, last_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0]   tdata_q, tdata_d;
  logic                tvalid_q, tvalid_d;
  logic                tlast_q, tlast_d;
  logic [NUM_REQ-1:0]  pop_q, pop_d;
  logic [NUM_REQ-1:0]  done_q, done_d;

  logic [IdxW-1:0]     win_idx;
  logic [IdxW-1:0]     cand;
  logic                win_found;

  // Search starts just past the previous owner so each requester waits at most one round.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand      = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = IdxW'((32'(last_q) + k) % NUM_REQ);
      if (!win_found && req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    last_d   = last_q;
    cnt_d    = cnt_q;
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    tlast_d  = tlast_q;
    pop_d    = '0;
    done_d   = '0;
    unique case (state_q)
      StIdle: begin
        if (win_found) begin
          state_d          = StSend;
          grant_d          = '0;
          grant_d[win_idx] = 1'b1;
          last_d           = win_idx;
          tdata_d          = data_in[32'(win_idx)*DATA_W +: DATA_W];
          pop_d[win_idx]   = 1'b1;
          cnt_d            = '0;
          tvalid_d         = 1'b1;
          tlast_d          = (PKT_LEN == 1);
        end
      end
      StSend: begin
        if (m_axis.tready) begin
          if (cnt_q == LastCnt) begin
            state_d  = StIdle;
            tvalid_d = 1'b0;
            tlast_d  = 1'b0;
            grant_d  = '0;
            done_d   = grant_q;
          end else begin
            cnt_d   = cnt_q + 1'b1;
            tdata_d = data_in[32'(last_q)*DATA_W +: DATA_W];
            pop_d   = grant_q;
            tlast_d = ((cnt_q + 1'b1) == LastCnt);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      grant_q  <= '0;
      last_q   <= LastIdx;
      cnt_q    <= '0;
      tdata_q  <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      pop_q    <= '0;
      done_q   <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      last_q   <= last_d;
      cnt_q    <= cnt_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      tlast_q  <= tlast_d;
      pop_q    <= pop_d;
      done_q   <= done_d;
    end
  end

  assign pop           = pop_q;
  assign done          = done_q;
  assign grant         = grant_q;
  assign busy          = (state_q == StSend);
  assign m_axis.tvalid = tvalid_q;
  assign m_axis.tlast  = tlast_q;
  assign m_axis.tdata  = tdata_q;

endmodule

// File: tb/tb_axis_m_rr_sched.sv
// Directed bench for axis_m_rr_sched: a PKT_LEN=4 instance and a PKT_LEN=1 instance.
module tb_axis_m_rr_sched;

  logic         aclk = 1'b0;
  logic         rst  = 1'b1;
  logic [3:0]   req  = '0;
  logic [127:0] data_in = '0;
  logic [3:0]   pop, done, grant;
  logic         busy;
  logic [3:0]   req_b = '0;
  logic [127:0] data_b = '0;
  logic [3:0]   pop_b, done_b, grant_b;
  logic         busy_b;
  bit           src_auto = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  int          pop_cnt [4];
  int          done_cnt [4];
  logic [31:0] beat_q [$];
  int          gnt_q [$];
  int          gap_q [$];
  int          last_pos_q [$];
  int          beat_in_pkt = 0;
  int          idle_run = 0;
  bit          seen_pkt = 1'b0;
  logic        prev_valid = 1'b0, prev_ready = 1'b0, prev_last = 1'b0;
  logic [31:0] prev_data = '0;
  logic [3:0]  prev_grant = '0;

  axis_m_rr_sched_if #(.DATA_W(32)) axis ();
  axis_m_rr_sched_if #(.DATA_W(32)) axis_b ();

  axis_m_rr_sched #(.NUM_REQ(4), .DATA_W(32), .PKT_LEN(4)) u_dut (
    .aclk(aclk), .rst(rst), .req(req), .data_in(data_in), .pop(pop), .done(done),
    .grant(grant), .busy(busy), .m_axis(axis)
  );

  axis_m_rr_sched #(.NUM_REQ(4), .DATA_W(32), .PKT_LEN(1)) u_dut_p1 (
    .aclk(aclk), .rst(rst), .req(req_b), .data_in(data_b), .pop(pop_b), .done(done_b),
    .grant(grant_b), .busy(busy_b), .m_axis(axis_b)
  );

  always #5 aclk = ~aclk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns just after a rising edge; the auto source advances on each pop.
  task automatic tick();
    @(posedge aclk);
    #1;
    if (src_auto)
      for (int i = 0; i < 4; i++)
        if (pop[i]) data_in[i*32 +: 32] = data_in[i*32 +: 32] + 32'd1;
  endtask

  task automatic wait_done(input int target, input int tmo);
    int seen = 0;
    for (int n = 0; n < tmo && seen < target; n++) begin
      tick();
      if (done != 4'b0) seen++;
    end
    check("done_seen", seen, target);
  endtask

  task automatic clear_stats();
    for (int i = 0; i < 4; i++) begin
      pop_cnt[i]  = 0;
      done_cnt[i] = 0;
    end
    beat_q.delete();
    gnt_q.delete();
    gap_q.delete();
    last_pos_q.delete();
    beat_in_pkt = 0;
    seen_pkt    = 1'b0;
  endtask

  always @(negedge aclk) begin
    if (rst) begin
      prev_valid  = 1'b0;
      beat_in_pkt = 0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        pop_cnt[i]  += int'(pop[i]);
        done_cnt[i] += int'(done[i]);
      end
      if (grant != 4'b0 && prev_grant == 4'b0) gnt_q.push_back(int'(grant));
      if (axis.tvalid && !prev_valid && seen_pkt) gap_q.push_back(idle_run);
      if (!axis.tvalid) idle_run++;
      else idle_run = 0;
      if (prev_valid && !prev_ready) begin
        check("hold_valid", axis.tvalid, 1);
        check("hold_data", axis.tdata, prev_data);
        check("hold_last", axis.tlast, prev_last);
      end
      if (axis.tvalid && axis.tready) begin
        beat_q.push_back(axis.tdata);
        beat_in_pkt++;
        if (axis.tlast) begin
          last_pos_q.push_back(beat_in_pkt);
          beat_in_pkt = 0;
          seen_pkt    = 1'b1;
        end
      end
      prev_valid = axis.tvalid;
      prev_ready = axis.tready;
      prev_data  = axis.tdata;
      prev_last  = axis.tlast;
    end
    prev_grant = grant;
  end

  initial begin
    axis.tready   = 1'b1;
    axis_b.tready = 1'b1;
    clear_stats();

    // Reset state
    tick();
    tick();
    check("rst_tvalid", axis.tvalid, 0);
    check("rst_tlast", axis.tlast, 0);
    check("rst_tdata", axis.tdata, 0);
    check("rst_grant", grant, 0);
    check("rst_busy", busy, 0);
    check("rst_pop_done", {pop, done}, 0);
    rst = 1'b0;

    // Single requester, full packet
    data_in[31:0] = 32'haaaa_bbbb;
    req = 4'b0001;
    tick();
    check("t1_tvalid", axis.tvalid, 1);
    check("t1_grant", grant, 4'b0001);
    check("t1_pop", pop, 4'b0001);
    check("t1_tdata", axis.tdata, 32'haaaa_bbbb);
    check("t1_tlast0", axis.tlast, 0);
    check("t1_busy", busy, 1);
    req = 4'b0000;
    wait_done(1, 20);
    tick();
    check("t1_beats", beat_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t1_data", beat_q[i], 32'haaaa_bbbb);
    check("t1_tlast_pos", last_pos_q[0], 4);
    check("t1_pops", pop_cnt[0], 4);
    check("t1_done", done_cnt[0], 1);
    check("t1_idle", {busy, axis.tvalid}, 0);

    // All requesting: strict round-robin from a fresh reset
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_stats();
    data_in = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
    req = 4'b1111;
    wait_done(5, 60);
    req = 4'b0000;
    tick();
    check("t2_ngrants", gnt_q.size(), 5);
    check("t2_g0", gnt_q[0], 4'b0001);
    check("t2_g1", gnt_q[1], 4'b0010);
    check("t2_g2", gnt_q[2], 4'b0100);
    check("t2_g3", gnt_q[3], 4'b1000);
    check("t2_g4", gnt_q[4], 4'b0001);
    check("t2_ngaps", gap_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t2_gap", gap_q[i], 1);
    check("t2_beats", beat_q.size(), 20);
    check("t2_d0", beat_q[0], 32'h1111_1111);
    check("t2_d1", beat_q[4], 32'h2222_2222);
    check("t2_d2", beat_q[8], 32'h3333_3333);
    check("t2_d3", beat_q[12], 32'h4444_4444);
    check("t2_d4", beat_q[16], 32'h1111_1111);
    check("t2_done0", done_cnt[0], 2);
    check("t2_done3", done_cnt[3], 1);

    // Backpressure mid-packet with an advancing source
    clear_stats();
    src_auto = 1'b1;
    data_in[31:0] = 32'h0000_0100;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    tick();
    tick();
    axis.tready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_pop", pop, 0);
    end
    axis.tready = 1'b1;
    wait_done(1, 20);
    tick();
    src_auto = 1'b0;
    check("t3_beats", beat_q.size(), 4);
    for (int i = 0; i < 4; i++) check("t3_data", beat_q[i], 32'h100 + i);
    check("t3_pops", pop_cnt[0], 4);
    check("t3_done", done_cnt[0], 1);
    check("t3_tlast_pos", last_pos_q[0], 4);

    // Owner drops req after grant
    clear_stats();
    data_in[95:64] = 32'h5555_6666;
    req = 4'b0100;
    tick();
    check("t4_grant", grant, 4'b0100);
    req = 4'b0000;
    wait_done(1, 20);
    tick();
    check("t4_beats", beat_q.size(), 4);
    check("t4_pops", pop_cnt[2], 4);
    check("t4_done", done_cnt[2], 1);

    // Asynchronous reset during beat 2
    clear_stats();
    req = 4'b0001;
    tick();
    check("t5_grant0", grant, 4'b0001);
    req = 4'b0000;
    tick();
    #2 rst = 1'b1;
    #1;
    check("t5_rst_tvalid", axis.tvalid, 0);
    check("t5_rst_grant", grant, 0);
    check("t5_rst_busy", busy, 0);
    req = 4'b1010;
    @(posedge aclk);
    #1 rst = 1'b0;
    tick();
    check("t5_grant1", grant, 4'b0010);
    req = 4'b0000;
    wait_done(1, 20);
    tick();

    // Single-beat packet build
    data_b[95:64] = 32'hcccc_dddd;
    req_b = 4'b0100;
    tick();
    req_b = 4'b0000;
    check("t6_tvalid", axis_b.tvalid, 1);
    check("t6_tlast", axis_b.tlast, 1);
    check("t6_tdata", axis_b.tdata, 32'hcccc_dddd);
    check("t6_pop", pop_b, 4'b0100);
    check("t6_done_early", done_b, 0);
    tick();
    check("t6_done", done_b, 4'b0100);
    check("t6_tvalid_off", axis_b.tvalid, 0);
    check("t6_pop_once", pop_b, 0);
    tick();
    check("t6_done_once", done_b, 0);
    check("t6_busy", busy_b, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
